// File: rtl/traffic_sensor_conditioner.sv
// Conditions raw per-lane queue sensors: 2-flop sync, symmetric debounce and
// stuck-high detection with sticky, clearable fault flags.
module traffic_sensor_conditioner #(
  parameter int NUM_LANES    = 4,
  parameter int DEBOUNCE     = 4,
  parameter int STUCK_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] raw_ss,
  input  logic [NUM_LANES-1:0] raw_fs,
  input  logic                 fault_clr,
  output logic [NUM_LANES-1:0] input_ss,
  output logic [NUM_LANES-1:0] input_fs,
  output logic [NUM_LANES-1:0] fault_ss,
  output logic [NUM_LANES-1:0] fault_fs,
  output logic                 fault_any
);

  localparam int NCH = 2 * NUM_LANES;
  localparam int CW  = $clog2(DEBOUNCE + 1);
  localparam int SW  = $clog2(STUCK_CYCLES);

  // Channels 0..NUM_LANES-1 are 1st-car sensors, the upper half 5th-car sensors.
  logic [NCH-1:0] raw_all;
  logic [NCH-1:0] filt_all;
  logic [NCH-1:0] flt_all;

  assign raw_all = {raw_fs, raw_ss};

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic          s1_reg, s2_reg;
      logic          filt_reg, filt_next;
      logic          flt_reg, flt_next;
      logic [CW-1:0] cnt_reg, cnt_next;
      logic [SW-1:0] scnt_reg, scnt_next;

      // Debounce: a change needs DEBOUNCE consecutive disagreeing synced samples.
      always_comb begin
        filt_next = filt_reg;
        cnt_next  = '0;
        if (s2_reg != filt_reg) begin
          if (cnt_reg == CW'(DEBOUNCE - 1)) begin
            filt_next = s2_reg;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      // Stuck detect: clear wins over a same-edge threshold hit.
      always_comb begin
        flt_next  = flt_reg;
        scnt_next = '0;
        if (fault_clr) begin
          flt_next = 1'b0;
        end else if (filt_reg && !flt_reg) begin
          if (scnt_reg == SW'(STUCK_CYCLES - 1)) begin
            flt_next = 1'b1;
          end else begin
            scnt_next = scnt_reg + 1'b1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          s1_reg   <= 1'b0;
          s2_reg   <= 1'b0;
          filt_reg <= 1'b0;
          cnt_reg  <= '0;
          flt_reg  <= 1'b0;
          scnt_reg <= '0;
        end else begin
          s1_reg   <= raw_all[gi];
          s2_reg   <= s1_reg;
          filt_reg <= filt_next;
          cnt_reg  <= cnt_next;
          flt_reg  <= flt_next;
          scnt_reg <= scnt_next;
        end
      end

      assign filt_all[gi] = filt_reg;
      assign flt_all[gi]  = flt_reg;
    end
  endgenerate

  // A faulted 1st-car sensor also suppresses the long-queue report.
  assign input_ss  = filt_all[NUM_LANES-1:0] & ~flt_all[NUM_LANES-1:0];
  assign input_fs  = filt_all[NCH-1:NUM_LANES] & ~flt_all[NCH-1:NUM_LANES] & input_ss;
  assign fault_ss  = flt_all[NUM_LANES-1:0];
  assign fault_fs  = flt_all[NCH-1:NUM_LANES];
  assign fault_any = |flt_all;

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Self-checking bench: directed scenarios plus random stimulus, every cycle
// compared against a timestamp-based reference model of the conditioner.
module tb_traffic_sensor_conditioner;

  localparam int NL    = 4;
  localparam int DB    = 4;
  localparam int ST    = 20;
  localparam int NCH   = 2 * NL;
  localparam int MAXE  = 6000;

  logic          clk = 1'b0;
  logic          rst;
  logic [NL-1:0] raw_ss, raw_fs;
  logic          fault_clr;
  logic [NL-1:0] input_ss, input_fs, fault_ss, fault_fs;
  logic          fault_any;

  int checks   = 0;
  int failures = 0;

  traffic_sensor_conditioner #(
    .NUM_LANES(NL), .DEBOUNCE(DB), .STUCK_CYCLES(ST)
  ) dut (
    .clk(clk), .rst(rst), .raw_ss(raw_ss), .raw_fs(raw_fs), .fault_clr(fault_clr),
    .input_ss(input_ss), .input_fs(input_fs), .fault_ss(fault_ss),
    .fault_fs(fault_fs), .fault_any(fault_any)
  );

  always #5 clk = ~clk;

  // Reference model: input history per edge, filtered/fault state per channel,
  // and the edge from which the stuck interval is measured.
  bit [NCH-1:0] raw_h [MAXE];
  bit           rst_h [MAXE];
  bit           clr_h [MAXE];
  bit           m_filt [NCH];
  bit           m_flt  [NCH];
  int           m_start [NCH];
  int           last_rst = -1;
  int           edge_n = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, edge_n - 1, got, exp);
    end
  endtask

  // Value the synchroniser presents at edge n: raw from two edges earlier,
  // forced to 0 if either pipeline edge was a reset edge.
  function automatic bit seen(int n, int j);
    if (n < 2) return 1'b0;
    if (rst_h[n-2] || rst_h[n-1]) return 1'b0;
    return raw_h[n-2][j];
  endfunction

  task automatic model_edge(int n);
    bit old_f, chg;
    if (rst_h[n]) begin
      last_rst = n;
      for (int j = 0; j < NCH; j++) begin
        m_filt[j]  = 1'b0;
        m_flt[j]   = 1'b0;
        m_start[j] = n;
      end
      return;
    end
    for (int j = 0; j < NCH; j++) begin
      old_f = m_filt[j];
      chg = 1'b1;
      for (int k = 0; k < DB; k++) begin
        if (n - k <= last_rst) chg = 1'b0;
        else if (seen(n - k, j) == old_f) chg = 1'b0;
      end
      if (clr_h[n]) begin
        m_flt[j]   = 1'b0;
        m_start[j] = n;
      end else if (old_f && !m_flt[j] && (n - m_start[j] == ST)) begin
        m_flt[j] = 1'b1;
      end
      if (chg) begin
        m_filt[j] = !old_f;
        if (!old_f) m_start[j] = n;
      end
    end
  endtask

  task automatic compare_model();
    logic [NL-1:0] e_ss, e_fs, e_fltss, e_fltfs;
    for (int l = 0; l < NL; l++) begin
      e_ss[l]    = m_filt[l] & ~m_flt[l];
      e_fs[l]    = m_filt[NL+l] & ~m_flt[NL+l] & e_ss[l];
      e_fltss[l] = m_flt[l];
      e_fltfs[l] = m_flt[NL+l];
    end
    check_eq("input_ss", 32'(input_ss), 32'(e_ss));
    check_eq("input_fs", 32'(input_fs), 32'(e_fs));
    check_eq("fault_ss", 32'(fault_ss), 32'(e_fltss));
    check_eq("fault_fs", 32'(fault_fs), 32'(e_fltfs));
    check_eq("fault_any", 32'(fault_any), 32'(|{e_fltss, e_fltfs}));
  endtask

  // One clock: drive inputs, take the edge, update the model, compare 1 time unit later.
  task automatic step(input logic r, input logic [NL-1:0] ss, input logic [NL-1:0] fs,
                      input logic clr);
    rst = r; raw_ss = ss; raw_fs = fs; fault_clr = clr;
    raw_h[edge_n] = {fs, ss};
    rst_h[edge_n] = r;
    clr_h[edge_n] = clr;
    @(posedge clk);
    model_edge(edge_n);
    edge_n++;
    #1;
    compare_model();
  endtask

  initial begin
    logic [NL-1:0] rs, rf;
    int hi_cnt;
    logic flt_exp;
    rst = 1'b1; raw_ss = '0; raw_fs = '0; fault_clr = 1'b0;
    #2;

    for (int k = 0; k < 3; k++) step(1'b1, '0, '0, 1'b0);
    check_eq("reset_ss", 32'(input_ss), 32'd0);
    check_eq("reset_any", 32'(fault_any), 32'd0);
    for (int k = 0; k < 5; k++) step(1'b0, '0, '0, 1'b0);
    $display("phase reset done edge=%0d", edge_n);

    // Scenario 1: lane 0 queue sensor held then released.
    for (int k = 0; k < 30; k++) begin
      step(1'b0, (k < 15) ? 4'b0001 : 4'b0000, '0, 1'b0);
      check_eq("t1_input_ss", 32'(input_ss), (k >= 5 && k < 20) ? 32'd1 : 32'd0);
    end
    $display("phase single_lane done edge=%0d", edge_n);

    // Scenario 2: 3-cycle glitch is rejected, 4-cycle pulse passes for 4 cycles.
    for (int k = 0; k < 13; k++) begin
      step(1'b0, (k < 3) ? 4'b0100 : 4'b0000, '0, 1'b0);
      check_eq("t2_glitch", 32'(input_ss), 32'd0);
    end
    hi_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      step(1'b0, (k < 4) ? 4'b0100 : 4'b0000, '0, 1'b0);
      if (input_ss[2]) hi_cnt++;
    end
    check_eq("t2_pulse_len", 32'(hi_cnt), 32'd4);
    $display("phase debounce done edge=%0d", edge_n);

    // Scenario 3: long queue gated by queue-present.
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 4'b0000, 4'b0010, 1'b0);
      check_eq("t3_fs_gated", 32'(input_fs), 32'd0);
    end
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 4'b0010, 4'b0010, 1'b0);
      check_eq("t3_fs_with_ss", 32'(input_fs), (k >= 5) ? 32'd2 : 32'd0);
    end
    for (int k = 0; k < 10; k++) step(1'b0, '0, '0, 1'b0);
    $display("phase fs_gating done edge=%0d", edge_n);

    // Scenarios 4/5: stuck lane 3, clears mid-fault and on the threshold edge.
    for (int k = 0; k < 100; k++) begin
      step(1'b0, 4'b1000, '0, (k == 30 || k == 55 || k == 75));
      flt_exp = (k >= 25 && k < 30) || (k >= 50 && k < 55) || (k >= 95);
      check_eq("t4_fault_ss", 32'(fault_ss), flt_exp ? 32'd8 : 32'd0);
      check_eq("t4_input_ss", 32'(input_ss), (k >= 5 && !flt_exp) ? 32'd8 : 32'd0);
    end
    $display("phase stuck done edge=%0d", edge_n);

    // Scenario 6: reset while faulted and with lane 0 mid-debounce.
    step(1'b0, 4'b1001, '0, 1'b0);
    step(1'b0, 4'b1001, '0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step(k == 0, 4'b1001, '0, 1'b0);
      check_eq("t6_input_ss", 32'(input_ss), (k >= 6) ? 32'd9 : 32'd0);
      check_eq("t6_fault_any", 32'(fault_any), 32'd0);
    end
    for (int k = 0; k < 10; k++) step(1'b0, '0, '0, 1'b0);
    $display("phase midreset done edge=%0d", edge_n);

    // Random: slowly toggling sensors, occasional clears and rare resets.
    rs = '0; rf = '0;
    for (int k = 0; k < 4000; k++) begin
      for (int l = 0; l < NL; l++) begin
        if ($urandom_range(15) == 0) rs[l] = ~rs[l];
        if ($urandom_range(15) == 0) rf[l] = ~rf[l];
      end
      step($urandom_range(499) == 0, rs, rf, $urandom_range(63) == 0);
    end
    $display("phase random done edge=%0d", edge_n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
